// File: rtl/aes128_cipher_iter.sv
// +-----------------------------------------------------------------------------+
// | aes128_cipher_iter: iterative AES-128 encryption, one round per clock,      |
// | with valid/ready handshakes. Optional macro KEY_LATCH_EN latches the key.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module aes128_cipher_iter #(
  parameter int NR    = 10,
  parameter int KEY_W = (NR + 1) * 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_W-1:0]   expandedKey,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       plaintext,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       ciphertext,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [3:0] c_nr = 4'(NR);

  // FIPS-197 S-box; entry 0 sits in the most significant byte
  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return c_sbox[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  fsm_t             r_fsm, w_fsm_nxt;
  logic [127:0]     r_state, r_ct;
  logic [3:0]       r_round;
  logic             w_accept, w_step, w_last;
  logic [KEY_W-1:0] w_key;
  logic [127:0]     w_rk [0:15];
  logic [127:0]     w_sub, w_shift, w_mix, w_round_out;

`ifdef KEY_LATCH_EN
  logic [KEY_W-1:0] r_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_key <= '0;
    else if (w_accept) r_key <= expandedKey;
  end

  assign w_key = r_key;
`else
  assign w_key = expandedKey;
`endif

  // Unreachable counter values select an all-zero key
  for (genvar i = 0; i < 16; i++) begin : g_rk
    if (i <= NR) begin : g_valid
      assign w_rk[i] = w_key[128*i +: 128];
    end else begin : g_unused
      assign w_rk[i] = '0;
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign w_sub[127-8*i -: 8] = sbox(r_state[127-8*i -: 8]);
  end

  // Byte b = row + 4*col; row r rotates left by r columns
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int c_dst = r + 4 * c;
      localparam int c_src = r + 4 * ((c + r) % 4);
      assign w_shift[127-8*c_dst -: 8] = w_sub[127-8*c_src -: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_shift[127-32*c -: 8];
    assign w_a1 = w_shift[119-32*c -: 8];
    assign w_a2 = w_shift[111-32*c -: 8];
    assign w_a3 = w_shift[103-32*c -: 8];
    assign w_mix[127-32*c -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign w_mix[119-32*c -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign w_mix[111-32*c -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign w_mix[103-32*c -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

  assign w_round_out = (w_last ? w_shift : w_mix) ^ w_rk[r_round];
  assign ciphertext  = r_ct;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    w_accept  = 1'b0;
    w_step    = 1'b0;
    w_last    = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept  = 1'b1;
          w_fsm_nxt = ROUND;
        end
      end
      ROUND: begin
        if (r_round >= 4'd1 && r_round <= c_nr) begin
          busy   = 1'b1;
          w_step = 1'b1;
          if (r_round == c_nr) begin
            w_last    = 1'b1;
            w_fsm_nxt = DONE;
          end
        end else begin
          w_fsm_nxt = IDLE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '0;
      r_round <= '0;
      r_ct    <= '0;
    end else if (w_accept) begin
      r_state <= plaintext ^ expandedKey[127:0];
      r_round <= 4'd1;
    end else if (w_step) begin
      r_state <= w_round_out;
      r_round <= w_last ? 4'd0 : r_round + 4'd1;
      if (w_last) r_ct <= w_round_out;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes128_cipher_iter.sv
// +-----------------------------------------------------------------------------+
// | tb_aes128_cipher_iter: known-answer and randomized checks of                |
// | aes128_cipher_iter against a byte-array AES model.                          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_aes128_cipher_iter;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1407:0] expandedKey;
  logic [127:0]  plaintext, ciphertext;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [7:0]    sb [256];
  logic [1407:0] ek_b, ek_c;

  aes128_cipher_iter dut (
    .clk         (clk),
    .rst         (rst),
    .expandedKey (expandedKey),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .plaintext   (plaintext),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ciphertext  (ciphertext),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box derived from the field inverse plus affine map, not from a table
  task automatic build_sbox();
    logic [7:0]  inv;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      d = {inv, inv};
      sb[x] = inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] ek;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      ek[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ek;
  endfunction

  function automatic logic [127:0] model_enc(input logic [1407:0] ek, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk, res;
    rk = ek[127:0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      rk = ek[128*rnd +: 128];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a block while the DUT is idle; returns just after the accepting edge
  task automatic start_block(input logic [1407:0] ek, input logic [127:0] pt);
    expandedKey = ek;
    plaintext   = pt;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
    plaintext   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic finish_block(output logic [127:0] ct, output int waited, output bit ok);
    waited = 0;
    while (!out_valid && waited < 40) begin
      tick();
      waited++;
    end
    ok = out_valid;
    ct = ciphertext;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
    plaintext = '0; expandedKey = '0;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (ciphertext !== 128'h0) begin tests_failed++; $display("FAIL reset_ciphertext: got %h expected 0", ciphertext); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips_b();
    logic [127:0] ct; int waited; bit ok;
    start_block(ek_b, PT_B);
    finish_block(ct, waited, ok);
    // Clocks counted inclusive of the accepting (AddRoundKey) edge
    tests_run++;
    if (!ok || waited + 1 != 11) begin
      tests_failed++; $display("FAIL fips_b_latency: got %0d clocks expected 11", waited + 1);
    end
    tests_run++;
    if (!ok || ct !== CT_B) begin tests_failed++; $display("FAIL fips_b_ct: got %h expected %h", ct, CT_B); end
    consume();
  endtask

  task automatic test_fips_c1();
    logic [127:0] ct; int waited; bit ok;
    start_block(ek_c, PT_C);
    finish_block(ct, waited, ok);
    tests_run++;
    if (!ok || ct !== CT_C) begin tests_failed++; $display("FAIL fips_c1_ct: got %h expected %h", ct, CT_C); end
    consume();
  endtask

  task automatic test_random();
    logic [127:0] key, pt, exp_ct, ct; logic [1407:0] ek; int waited; bit ok;
    for (int n = 0; n < 8; n++) begin
      key    = {$urandom, $urandom, $urandom, $urandom};
      pt     = {$urandom, $urandom, $urandom, $urandom};
      ek     = expand(key);
      exp_ct = model_enc(ek, pt);
      start_block(ek, pt);
      finish_block(ct, waited, ok);
      tests_run++;
      if (!ok || ct !== exp_ct) begin
        tests_failed++; $display("FAIL random_ct[%0d]: got %h expected %h", n, ct, exp_ct);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ct; int waited; bit ok; bit stable;
    start_block(ek_b, PT_B);
    finish_block(ct, waited, ok);
    stable = ok && (ct === CT_B);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ciphertext !== CT_B || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    tests_run++;
    if (!stable) begin
      tests_failed++; $display("FAIL backpressure_hold: got ct=%h in_ready=%b out_valid=%b expected ct=%h 0 1",
                               ciphertext, in_ready, out_valid, CT_B);
    end
    consume();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL backpressure_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    start_block(ek_c, PT_C);
    finish_block(ct, waited, ok);
    tests_run++;
    if (!ok || ct !== CT_C) begin tests_failed++; $display("FAIL b2b_c1_ct: got %h expected %h", ct, CT_C); end
    consume();
    start_block(ek_b, PT_B);
    finish_block(ct, waited, ok);
    tests_run++;
    if (!ok || ct !== CT_B) begin tests_failed++; $display("FAIL b2b_b_ct: got %h expected %h", ct, CT_B); end
    consume();
  endtask

  task automatic test_busy_input();
    logic [127:0] ct; int waited; bit ok;
    start_block(ek_b, PT_B);
    tick(); tick(); tick();
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL busy_flags: got busy=%b in_ready=%b expected 1 0", busy, in_ready);
    end
    plaintext = PT_C;
    in_valid  = 1'b1;
    tick(); tick();
    in_valid  = 1'b0;
    finish_block(ct, waited, ok);
    tests_run++;
    if (!ok || ct !== CT_B) begin tests_failed++; $display("FAIL busy_ignore_ct: got %h expected %h", ct, CT_B); end
    consume();
  endtask

  task automatic test_reset_mid();
    logic [127:0] ct; int waited; bit ok; bit seen;
    start_block(ek_b, PT_B);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_flags: got out_valid=%b in_ready=%b busy=%b expected 0 1 0",
                               out_valid, in_ready, busy);
    end
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin tests_failed++; $display("FAIL reset_mid_abort: got out_valid=1 expected 0"); end
    start_block(ek_b, PT_B);
    finish_block(ct, waited, ok);
    tests_run++;
    if (!ok || ct !== CT_B) begin tests_failed++; $display("FAIL reset_mid_rerun_ct: got %h expected %h", ct, CT_B); end
    consume();
  endtask

  task automatic test_key_change();
    logic [127:0] ct; int waited; bit ok;
    start_block(ek_b, PT_B);
    tick();
    expandedKey = ek_c;
    finish_block(ct, waited, ok);
    tests_run++;
`ifdef KEY_LATCH_EN
    if (!ok || ct !== CT_B) begin tests_failed++; $display("FAIL key_latch_ct: got %h expected %h", ct, CT_B); end
`else
    if (!ok || ct === CT_B) begin tests_failed++; $display("FAIL key_live_ct: got %h expected a value other than %h", ct, CT_B); end
`endif
    consume();
  endtask

  initial begin
    build_sbox();
    ek_b = expand(KEY_B);
    ek_c = expand(KEY_C);
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_random();
    test_back_to_back();
    test_busy_input();
    test_reset_mid();
    test_key_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
